// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM states, NZCV flag bit positions and default operand width
// for the iterative multiply unit.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/mul_step.sv
// mul_step: one combinational radix-2 iteration. Conditionally adds or subtracts
// the shifted multiplicand into the partial product, then shifts the multiplicand left.
module mul_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_pp,
    input  logic [W-1:0] i_mcand,
    input  logic         i_bit,
    input  logic         i_sub,
    output logic [W-1:0] o_pp,
    output logic [W-1:0] o_mcand
);

    assign o_pp    = !i_bit ? i_pp : (i_sub ? i_pp - i_mcand : i_pp + i_mcand);
    assign o_mcand = i_mcand << 1;

endmodule

// File: rtl/mul_unit.sv
// mul_unit: WIDTH-cycle shift-add multiplier/accumulator with NZCV flag update.
// Define MUL_UNIT_LONG_MUL_EN to add the signed/unsigned long (2*WIDTH) multiply.
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_c,
    input  logic             acc,
    input  logic             s,
    input  logic [3:0]       nzcv_in,
`ifdef MUL_UNIT_LONG_MUL_EN
    input  logic             long_op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_d,
    output logic [WIDTH-1:0] result_hi,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzcv_out
);

`ifdef MUL_UNIT_LONG_MUL_EN
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [PW-1:0]    r_pp;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_s;
    logic [3:0]       r_nzcv;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_nzcv_out;
    logic [PW-1:0]    w_pp_next;
    logic [PW-1:0]    w_mcand_next;
    logic [PW-1:0]    w_mcand_init;
    logic [PW-1:0]    w_addend;
    logic [3:0]       w_nzcv_next;
    logic             w_sub;
    logic             w_last;
    logic             w_accept;
    logic             w_n;
    logic             w_z;

    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_accept = start && ready && !flush;

`ifdef MUL_UNIT_LONG_MUL_EN
    logic             r_long;
    logic             r_signed;
    logic [WIDTH-1:0] r_result_hi;
    logic [WIDTH-1:0] w_hi;

    assign w_mcand_init = {{WIDTH{signed_op & op_a[WIDTH-1]}}, op_a};
    assign w_addend     = !acc ? '0 : (long_op ? {op_d, op_c} : {{WIDTH{1'b0}}, op_c});
    // Two's complement multiplier: its MSB carries weight -2^(WIDTH-1).
    assign w_sub        = r_signed && w_last;
    assign w_hi         = r_long ? w_pp_next[PW-1:WIDTH] : '0;
    assign w_n          = r_long ? w_hi[WIDTH-1] : w_pp_next[WIDTH-1];
    assign w_z          = (w_pp_next[WIDTH-1:0] == '0) && (w_hi == '0);
    assign result_hi    = r_result_hi;
`else
    assign w_mcand_init = op_a;
    assign w_addend     = acc ? op_c : '0;
    assign w_sub        = 1'b0;
    assign w_n          = w_pp_next[WIDTH-1];
    assign w_z          = w_pp_next[WIDTH-1:0] == '0;
`endif

    mul_step #(.W(PW)) u_step (
        .i_pp    (r_pp),
        .i_mcand (r_mcand),
        .i_bit   (r_mplier[0]),
        .i_sub   (w_sub),
        .o_pp    (w_pp_next),
        .o_mcand (w_mcand_next)
    );

    always_comb begin
        w_nzcv_next = r_nzcv;
        if (r_s) begin
            w_nzcv_next[NZCV_N] = w_n;
            w_nzcv_next[NZCV_Z] = w_z;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = r_state != RUN;
        done         = r_state == DONE;
        if (flush)
            w_state_next = IDLE;
        else if (r_state == RUN)
            w_state_next = w_last ? DONE : RUN;
        else
            w_state_next = start ? RUN : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_pp       <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            r_s        <= 1'b0;
            r_nzcv     <= '0;
            r_result   <= '0;
            r_nzcv_out <= '0;
`ifdef MUL_UNIT_LONG_MUL_EN
            r_long      <= 1'b0;
            r_signed    <= 1'b0;
            r_result_hi <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_pp     <= w_addend;
                r_mcand  <= w_mcand_init;
                r_mplier <= op_b;
                r_cnt    <= '0;
                r_s      <= s;
                r_nzcv   <= nzcv_in;
`ifdef MUL_UNIT_LONG_MUL_EN
                r_long   <= long_op;
                r_signed <= signed_op;
`endif
            end else if (r_state == RUN && !flush) begin
                r_pp     <= w_pp_next;
                r_mcand  <= w_mcand_next;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
                if (w_last) begin
                    r_result   <= w_pp_next[WIDTH-1:0];
                    r_nzcv_out <= w_nzcv_next;
`ifdef MUL_UNIT_LONG_MUL_EN
                    r_result_hi <= w_hi;
`endif
                end
            end
        end
    end

    assign result   = r_result;
    assign nzcv_out = r_nzcv_out;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed vectors for mul_unit; a scoreboard queue holds expected
// results and done cycles, and a monitor checks each done pulse against it.
module tb_mul_unit;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic [3:0]   nz;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] op_c = '0;
    logic         acc = 1'b0;
    logic         s = 1'b0;
    logic [3:0]   nzcv_in = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   nzcv_out;
    logic [W-1:0] hi_exp = '0;
`ifdef MUL_UNIT_LONG_MUL_EN
    logic         long_op = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] op_d = '0;
    logic [W-1:0] result_hi;
`endif

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    mul_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_c     (op_c),
        .acc      (acc),
        .s        (s),
        .nzcv_in  (nzcv_in),
`ifdef MUL_UNIT_LONG_MUL_EN
        .long_op  (long_op),
        .signed_op(signed_op),
        .op_d     (op_d),
        .result_hi(result_hi),
`endif
        .ready    (ready),
        .done     (done),
        .result   (result),
        .nzcv_out (nzcv_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", 64'(result), 64'(e.r));
                check("nzcv", 64'(nzcv_out), 64'(e.nz));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("ready_at_done", 64'(ready), 64'(1));
`ifdef MUL_UNIT_LONG_MUL_EN
                check("result_hi", 64'(result_hi), 64'(e.hi));
`endif
            end
        end
    end

    task automatic push(input logic [W-1:0] r, input logic [3:0] nz);
        exp_t e;
        e.r   = r;
        e.hi  = hi_exp;
        e.nz  = nz;
        e.cyc = cyc + W;
        q.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic ac, input logic ss, input logic [3:0] nz);
        @(negedge clk);
        op_a = a; op_b = b; op_c = c; acc = ac; s = ss; nzcv_in = nz;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_timeout", 64'(q.size()), 64'(0));
    endtask

    initial begin
        logic [W-1:0] prev_r;
        logic [3:0]   prev_nz;
        #3;
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_nzcv", 64'(nzcv_out), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        issue(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'b0011);
        push(32'd42, 4'b0011);
        drain(60);

        issue(32'hFFFF_FFFF, 32'd2, 32'd2, 1'b1, 1'b1, 4'b1010);
        push(32'h0, 4'b0110);
        drain(60);

        issue(32'd100, 32'd200, 32'd5, 1'b1, 1'b0, 4'b1001);
        push(32'd20005, 4'b1001);
        drain(60);

        issue(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 4'b0000);
        push(32'h8000_0000, 4'b1000);
        drain(60);

        // start during RUN must not disturb the captured operands
        issue(32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 4'b0101);
        push(32'd81, 4'b0001);
        @(negedge clk);
        op_a = 32'd1; op_b = 32'd1; start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        drain(60);

        // flush mid-RUN while start is also asserted
        prev_r  = result;
        prev_nz = nzcv_out;
        issue(32'd3, 32'd3, 32'd0, 1'b0, 1'b1, 4'b0000);
        @(negedge clk);
        op_a = 32'd11; start = 1'b1;
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        start = 1'b0;
        check("flush_ready", 64'(ready), 64'(1));
        check("flush_done", 64'(done), 64'(0));
        check("flush_result", 64'(result), 64'(prev_r));
        check("flush_nzcv", 64'(nzcv_out), 64'(prev_nz));
        repeat (40) @(negedge clk);

        // asynchronous reset mid-RUN
        issue(32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 4'b1111);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_ready", 64'(ready), 64'(1));
        check("arst_done", 64'(done), 64'(0));
        check("arst_result", 64'(result), 64'(0));
        check("arst_nzcv", 64'(nzcv_out), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 4'b0000);
        push(32'd4, 4'b0000);
        drain(60);

        // back-to-back: start held through DONE
        issue(32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 4'b0010);
        push(32'd25, 4'b0010);
        start = 1'b1;
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        push(32'd25, 4'b0010);
        check("b2b_ready_low", 64'(ready), 64'(0));
        drain(60);

`ifdef MUL_UNIT_LONG_MUL_EN
        long_op = 1'b1; signed_op = 1'b1; hi_exp = 32'hFFFF_FFFF;
        issue(32'hFFFF_FFFD, 32'd5, 32'd0, 1'b0, 1'b1, 4'b0000);
        push(32'hFFFF_FFF1, 4'b1000);
        drain(60);
        long_op = 1'b0; signed_op = 1'b0; hi_exp = '0;
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
